avm_image_streamer: RTL and testbench
=====================================

# avm_image_streamer

Parametrised Avalon-MM master that streams a raw image, byte by byte, into a UART-style register core (RX/TX/STATUS) and then reads back a fixed-length prediction result. It sits between the SRAM-side frame reader and the RS-232 IP in the camera pipeline. Frame geometry, channel count and result length are generics. It adds three things: a selectable transfer mode, done and busy reporting, and an optional poll watchdog.

## Interface
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- N_CH, 3, bytes per pixel
- RESULT_BYTES, 128, bytes read back after the frame
- TIMEOUT_CYC, 1000000, watchdog limit in cycles (used only with the watchdog macro)
- RX_BASE / TX_BASE / STATUS_BASE, 0 / 4 / 8, register byte addresses
- TX_OK_BIT / RX_OK_BIT, 6 / 7, bit positions in the STATUS register
- avm_clk  in  1  sole clock, rising edge
- avm_rst_n  in  1  reset, synchronous, active-low
- avm_address  out  5  register address
- avm_read / avm_write  out  1  transfer strobes, never both high
- avm_writedata  out  32  TX word; bits [31:8] are zero
- avm_readdata  in  32  read data, valid in the cycle waitrequest is low
- avm_waitrequest  in  1  slave stall
- i_start  in  1  one-cycle start pulse; ignored unless the block is IDLE
- i_mode  in  2  0 = send then receive, 1 = send only, 2 = receive only, 3 = treated as 0; sampled on i_start
- i_writedata  in  8  next image byte from upstream
- o_ready  out  1  one-cycle pulse: i_writedata consumed in this cycle
- o_readdata  out  8  last result byte
- o_readdata_valid  out  1  one-cycle pulse with each new o_readdata
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at normal completion
- o_error  out  1  watchdog abort flag, sticky
- o_state  out  3  state encoding, for debug

## Operation
- States:
  - IDLE=0, POLL_TX=1, WRITE_TX=2, POLL_RX=3, READ_RX=4, DONE=5, ERR=6.
  - The only path out of IDLE is i_start. Mode 2 enters POLL_RX; every other mode enters POLL_TX.
- A transfer completes in a cycle where the strobe is high and avm_waitrequest is low.
  - While stalled, address, strobe and data are held unchanged.
- POLL_TX:
  - Issues a read of STATUS_BASE.
  - On completion with readdata[TX_OK_BIT]=1: capture i_writedata, pulse o_ready the same cycle, go to WRITE_TX.
  - On completion with the bit clear: re-poll.
- WRITE_TX:
  - Issues a write of the captured byte to TX_BASE.
  - On completion, increment the byte counter.
  - If the counter reached N_TOT = IMG_W*IMG_H*N_CH: mode 1 goes to DONE, other modes go to POLL_RX. Otherwise go back to POLL_TX.
- POLL_RX: same as POLL_TX, but tests RX_OK_BIT and proceeds to READ_RX.
- READ_RX:
  - Reads RX_BASE. On completion, latch readdata[7:0] into o_readdata and pulse o_readdata_valid on the next cycle.
  - After RESULT_BYTES bytes go to DONE; otherwise go back to POLL_RX.
- DONE: pulses o_done for one cycle, then returns to IDLE. The counters are cleared on exit.
- Counter widths:
  - Byte counter: $clog2(N_TOT+1).
  - Result counter: $clog2(RESULT_BYTES+1).
  - Neither counter may wrap inside a transfer.
- o_error is cleared by i_start or by reset.

## Timing
- Reset values:
  - avm_read=0, avm_write=0, avm_address=STATUS_BASE, avm_writedata=0.
  - o_ready=0, o_readdata=0, o_readdata_valid=0, o_busy=0, o_done=0, o_error=0.
  - State = IDLE, all counters 0.
- A reset asserted mid-transfer takes effect on the next edge and drops the strobes immediately. No partial byte is counted.
- i_start → avm_read high with the STATUS address on the next cycle.
- With no stalls and the status bit always set, each byte takes exactly 2 cycles.
  - Send phase: 2*N_TOT cycles. Receive phase: 2*RESULT_BYTES cycles.
- o_ready is registered-free (combinational from the completing status read).
  - Upstream must advance i_writedata on the cycle after o_ready.
- o_readdata_valid lags RX read completion by 1 cycle. o_readdata holds its value until the next valid pulse.
- i_start while busy: ignored, with no effect on i_mode latch or o_error.

## Configuration
- Macro: AVM_IMAGE_STREAMER_WATCHDOG_EN.
- Defined:
  - A counter runs in POLL_TX and POLL_RX and resets on every status read that finds its bit set.
  - When it reaches TIMEOUT_CYC, the block drops the strobes and enters ERR.
  - ERR sets o_error=1 and returns to IDLE the next cycle. No o_done pulse is issued.
- Undefined: polling never times out, o_error is tied to 0, and the ERR state is unreachable.

## Test plan
All scenarios use IMG_W=4, IMG_H=2, N_CH=3 (N_TOT=24) and RESULT_BYTES=4.
- Mode 0, no stalls, status bits always set, i_start:
  - 24 writes of bytes 0..23 to address 4, each 2 cycles apart.
  - Then 4 reads from address 0, returning 0xA0..0xA3 on o_readdata with 4 valid pulses.
  - o_done pulses once; o_busy is high for exactly 57 cycles.
- Mode 1:
  - 24 writes, no RX_BASE access, o_done after the last write. Mode 2: zero writes, 4 reads.
- avm_waitrequest high for 3 cycles on every transfer:
  - Address, strobe and data stay stable through each stall.
  - Byte order is unchanged; each byte takes 8 cycles.
- TX_OK clear for 10 polls at byte 5: o_ready stays low, no write is issued, and the stream resumes with byte 5.
- Reset pulled low at byte 12 for 1 cycle: all outputs return to reset values. A new i_start resends from byte 0.
- With the watchdog enabled and TIMEOUT_CYC=20, status stuck at 0:
  - o_error is set after 20 cycles, the block returns to IDLE, and o_done never pulses.
  - The next i_start clears o_error.

Source files
------------

// File: rtl/avm_image_streamer_if.sv
// Avalon-MM register-bus bundle between the image streamer (master) and the
// UART-style register core (slave).
interface avm_image_streamer_if;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/avm_image_streamer.sv
// Avalon-MM master that streams a raw frame byte-by-byte into a UART register
// core, then reads back a fixed-length result. Optional poll watchdog: AVM_IMAGE_STREAMER_WATCHDOG_EN.
module avm_image_streamer #(
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int N_CH         = 3,
  parameter int RESULT_BYTES = 128,
  parameter int TIMEOUT_CYC  = 1000000,
  parameter int RX_BASE      = 0,
  parameter int TX_BASE      = 4,
  parameter int STATUS_BASE  = 8,
  parameter int TX_OK_BIT    = 6,
  parameter int RX_OK_BIT    = 7
) (
  input  logic                        avm_clk,
  input  logic                        avm_rst_n,
  avm_image_streamer_if.master        avm,
  input  logic                        i_start,
  input  logic [1:0]                  i_mode,
  input  logic [7:0]                  i_writedata,
  output logic                        o_ready,
  output logic [7:0]                  o_readdata,
  output logic                        o_readdata_valid,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic [2:0]                  o_state
);
  localparam int N_TOT = IMG_W * IMG_H * N_CH;
  localparam int BCW   = $clog2(N_TOT + 1);
  localparam int RCW   = $clog2(RESULT_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_POLL_TX  = 3'd1,
    S_WRITE_TX = 3'd2,
    S_POLL_RX  = 3'd3,
    S_READ_RX  = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } state_t;

  state_t         state, state_nxt;
  logic [1:0]     mode_q;
  logic [7:0]     tx_byte;
  logic [BCW-1:0] byte_cnt;
  logic [RCW-1:0] res_cnt;
  logic           rd_en, wr_en, xfer_done, wd_expired;
  logic           tx_ok, rx_ok, last_byte, last_res;

  // Strobes, address and data are pure functions of state, so they hold through stalls.
  assign rd_en     = (state == S_POLL_TX) || (state == S_POLL_RX) || (state == S_READ_RX);
  assign wr_en     = (state == S_WRITE_TX);
  assign xfer_done = (rd_en || wr_en) && !avm.avm_waitrequest;
  assign tx_ok     = avm.avm_readdata[TX_OK_BIT];
  assign rx_ok     = avm.avm_readdata[RX_OK_BIT];
  assign last_byte = (byte_cnt == BCW'(N_TOT - 1));
  assign last_res  = (res_cnt == RCW'(RESULT_BYTES - 1));

  assign avm.avm_read      = rd_en;
  assign avm.avm_write     = wr_en;
  assign avm.avm_writedata = {24'd0, tx_byte};
  assign avm.avm_address   = (state == S_WRITE_TX) ? 5'(TX_BASE) :
                             (state == S_READ_RX)  ? 5'(RX_BASE) : 5'(STATUS_BASE);

  assign o_busy  = (state != S_IDLE);
  assign o_done  = (state == S_DONE);
  assign o_state = state;

  wire unused_readdata = &{1'b0, avm.avm_readdata};

  // NOTE: every output of this block gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    case (state)
      S_IDLE:
        if (i_start) state_nxt = (i_mode == 2'd2) ? S_POLL_RX : S_POLL_TX;
      S_POLL_TX:
        if (xfer_done && tx_ok) begin
          o_ready   = 1'b1;
          state_nxt = S_WRITE_TX;
        end else if (wd_expired) begin
          state_nxt = S_ERR;
        end
      S_WRITE_TX:
        if (xfer_done) begin
          if (!last_byte)          state_nxt = S_POLL_TX;
          else if (mode_q == 2'd1) state_nxt = S_DONE;
          else                     state_nxt = S_POLL_RX;
        end
      S_POLL_RX:
        if (xfer_done && rx_ok) state_nxt = S_READ_RX;
        else if (wd_expired)    state_nxt = S_ERR;
      S_READ_RX:
        if (xfer_done) state_nxt = last_res ? S_DONE : S_POLL_RX;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      state            <= S_IDLE;
      mode_q           <= 2'd0;
      tx_byte          <= 8'd0;
      byte_cnt         <= '0;
      res_cnt          <= '0;
      o_readdata       <= 8'd0;
      o_readdata_valid <= 1'b0;
    end else begin
      state            <= state_nxt;
      o_readdata_valid <= 1'b0;
      if (state == S_IDLE && i_start) mode_q <= (i_mode == 2'd3) ? 2'd0 : i_mode;
      if (o_ready) tx_byte <= i_writedata;
      if (wr_en && xfer_done) byte_cnt <= byte_cnt + 1'b1;
      if (state == S_READ_RX && xfer_done) begin
        o_readdata       <= avm.avm_readdata[7:0];
        o_readdata_valid <= 1'b1;
        res_cnt          <= res_cnt + 1'b1;
      end
      if (state == S_DONE || state == S_ERR) begin
        byte_cnt <= '0;
        res_cnt  <= '0;
      end
    end
  end

`ifdef AVM_IMAGE_STREAMER_WATCHDOG_EN
  localparam int WCW = $clog2(TIMEOUT_CYC + 1);
  logic [WCW-1:0] wd_cnt;
  logic           error_q;
  logic           poll_hit;

  assign poll_hit   = xfer_done && (((state == S_POLL_TX) && tx_ok) || ((state == S_POLL_RX) && rx_ok));
  assign wd_expired = (wd_cnt == WCW'(TIMEOUT_CYC - 1));
  assign o_error    = error_q;

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if ((state == S_POLL_TX || state == S_POLL_RX) && !poll_hit) wd_cnt <= wd_cnt + 1'b1;
      else                                                         wd_cnt <= '0;
      if (state_nxt == S_ERR)            error_q <= 1'b1;
      else if (state == S_IDLE && i_start) error_q <= 1'b0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign wd_expired = 1'b0;
  assign o_error    = 1'b0;
`endif
endmodule

// File: tb/tb_avm_image_streamer.sv
// Self-checking bench for avm_image_streamer: a randomized register-core slave,
// an upstream byte source and a frame-level reference model.
module tb_avm_image_streamer;
  localparam int N_TOT = 24;
  localparam int R     = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [1:0] i_mode = 2'd0;
  logic [7:0] i_writedata = 8'd0;
  logic       o_ready, o_readdata_valid, o_busy, o_done, o_error;
  logic [7:0] o_readdata;
  logic [2:0] o_state;

  avm_image_streamer_if bus ();

  avm_image_streamer #(
    .IMG_W(4), .IMG_H(2), .N_CH(3), .RESULT_BYTES(R), .TIMEOUT_CYC(20)
  ) dut (
    .avm_clk(clk), .avm_rst_n(rst_n), .avm(bus.master),
    .i_start(i_start), .i_mode(i_mode), .i_writedata(i_writedata),
    .o_ready(o_ready), .o_readdata(o_readdata), .o_readdata_valid(o_readdata_valid),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0]  src [N_TOT];
  logic [7:0]  rx_data [R];
  logic [7:0]  last_rx = 8'd0;
  logic [31:0] wr_q [$];
  logic [7:0]  rx_seen [$];
  int          wr_cyc [$];
  int cyc = 0, busy_cnt = 0, done_cnt = 0, ready_cnt = 0, rx_reads = 0;
  int addr_bad = 0, stab_bad = 0, both_bad = 0;
  int stall_n = 0, wait_cnt = 0, blk_left = 0, blk_at = 5, src_ptr = 0, rx_idx = 0;
  bit adv_req = 1'b0, stuck = 1'b0, fin;
  bit prev_stall = 1'b0;
  logic [4:0]  p_addr;
  logic        p_rd, p_wr;
  logic [31:0] p_wd, st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Register-core slave and upstream source, updated just after each active edge.
  always @(posedge clk) begin
    #1;
    if (adv_req) begin
      adv_req = 1'b0;
      if (src_ptr < N_TOT - 1) src_ptr++;
      i_writedata = src[src_ptr];
    end
    bus.avm_readdata = $urandom;
    if (!(bus.avm_read || bus.avm_write)) begin
      bus.avm_waitrequest = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt < stall_n) begin
      bus.avm_waitrequest = 1'b1;
      wait_cnt++;
    end else begin
      bus.avm_waitrequest = 1'b0;
      wait_cnt = 0;
      if (bus.avm_read && bus.avm_address == 5'd8) begin
        st = $urandom;
        st[7] = !stuck;
        st[6] = !stuck;
        if (blk_left > 0 && wr_q.size() == blk_at) begin
          st[6] = 1'b0;
          blk_left--;
        end
        bus.avm_readdata = st;
      end else if (bus.avm_read && bus.avm_address == 5'd0) begin
        bus.avm_readdata = {24'($urandom), rx_data[rx_idx % R]};
        rx_idx++;
      end
    end
  end

  // Bus and output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (o_busy) busy_cnt++;
    if (o_done) done_cnt++;
    if (o_ready) begin ready_cnt++; adv_req = 1'b1; end
    if (o_readdata_valid) rx_seen.push_back(o_readdata);
    if (bus.avm_read && bus.avm_write) both_bad++;
    if (prev_stall && (bus.avm_address !== p_addr || bus.avm_read !== p_rd ||
                       bus.avm_write !== p_wr || bus.avm_writedata !== p_wd)) stab_bad++;
    prev_stall = (bus.avm_read || bus.avm_write) && bus.avm_waitrequest;
    p_addr = bus.avm_address; p_rd = bus.avm_read; p_wr = bus.avm_write; p_wd = bus.avm_writedata;
    if ((bus.avm_read || bus.avm_write) && !bus.avm_waitrequest) begin
      if (bus.avm_write) begin
        wr_q.push_back(bus.avm_writedata);
        wr_cyc.push_back(cyc);
        if (bus.avm_address != 5'd4) addr_bad++;
      end else if (bus.avm_address == 5'd0) rx_reads++;
      else if (bus.avm_address != 5'd8) addr_bad++;
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, ".read"},      bus.avm_read, 0);
    check({tag, ".write"},     bus.avm_write, 0);
    check({tag, ".address"},   bus.avm_address, 8);
    check({tag, ".writedata"}, bus.avm_writedata, 0);
    check({tag, ".ready"},     o_ready, 0);
    check({tag, ".readdata"},  o_readdata, 0);
    check({tag, ".valid"},     o_readdata_valid, 0);
    check({tag, ".busy"},      o_busy, 0);
    check({tag, ".done"},      o_done, 0);
    check({tag, ".error"},     o_error, 0);
    check({tag, ".state"},     o_state, 0);
  endtask

  task automatic start_frame(input logic [1:0] mode, input int stall, input int blk_n);
    stall_n = stall; blk_left = blk_n; blk_at = 5;
    wr_q.delete(); rx_seen.delete(); wr_cyc.delete();
    rx_reads = 0; busy_cnt = 0; done_cnt = 0; ready_cnt = 0; rx_idx = 0;
    src_ptr = 0; i_writedata = src[0];
    i_mode = mode; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_mode = 2'($urandom);
  endtask

  // Runs one frame and compares every observable against the frame-level model.
  task automatic run_frame(input logic [1:0] mode, input int stall, input int blk_n,
                           input bit poke, input string tag);
    bit has_tx, has_rx;
    int exp_busy, data_bad, gap_bad;
    has_tx = (mode != 2'd2);
    has_rx = (mode != 2'd1);
    exp_busy = ((has_tx ? 2 * N_TOT + blk_n : 0) + (has_rx ? 2 * R : 0)) * (stall + 1) + 1;
    start_frame(mode, stall, blk_n);
    fin = 1'b0;
    for (int i = 0; i < 2000 && !fin; i++) begin
      tick();
      i_start = poke && (i == 7);
      if (poke && i == 7) i_mode = 2'd2;
      if (done_cnt > 0) fin = 1'b1;
    end
    i_start = 1'b0;
    tick(); tick();
    if (has_rx) last_rx = rx_data[R-1];
    data_bad = 0; gap_bad = 0;
    foreach (wr_q[k]) if (k < N_TOT && wr_q[k] !== {24'd0, src[k]}) data_bad++;
    foreach (rx_seen[k]) if (k < R && rx_seen[k] !== rx_data[k]) data_bad++;
    if (blk_n == 0)
      for (int k = 1; k < wr_cyc.size(); k++)
        if (wr_cyc[k] - wr_cyc[k-1] != 2 * (stall + 1)) gap_bad++;
    check({tag, ".finished"},   fin, 1);
    check({tag, ".done_count"}, done_cnt, 1);
    check({tag, ".busy_cycles"}, busy_cnt, exp_busy);
    check({tag, ".ready_count"}, ready_cnt, has_tx ? N_TOT : 0);
    check({tag, ".writes"},     wr_q.size(), has_tx ? N_TOT : 0);
    check({tag, ".rx_reads"},   rx_reads, has_rx ? R : 0);
    check({tag, ".valids"},     rx_seen.size(), has_rx ? R : 0);
    check({tag, ".data"},       data_bad, 0);
    check({tag, ".write_gap"},  gap_bad, 0);
    check({tag, ".readdata_hold"}, o_readdata, last_rx);
    check({tag, ".idle"},       o_state, 0);
    check({tag, ".error"},      o_error, 0);
  endtask

  task automatic randomize_data();
    foreach (src[k]) src[k] = 8'($urandom);
    foreach (rx_data[k]) rx_data[k] = 8'($urandom);
  endtask

  initial begin
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = 32'd0;
    foreach (src[k]) src[k] = 8'(k);
    foreach (rx_data[k]) rx_data[k] = 8'hA0 + 8'(k);
    repeat (3) tick();
    reset_checks("reset");
    rst_n = 1'b1;
    tick();

    run_frame(2'd0, 0, 0, 1'b0, "mode0");
    randomize_data();
    run_frame(2'd1, 0, 0, 1'b0, "mode1");
    randomize_data();
    run_frame(2'd2, 0, 0, 1'b0, "mode2");
    randomize_data();
    run_frame(2'd0, 3, 0, 1'b0, "stall3");
    randomize_data();
    run_frame(2'd3, 0, 10, 1'b0, "txblock");
    randomize_data();
    run_frame(2'd1, 1, 0, 1'b1, "busy_start");

    // Reset pulled at byte 12, then a fresh frame from byte 0.
    randomize_data();
    start_frame(2'd0, 0, 0);
    fin = 1'b0;
    for (int i = 0; i < 500 && !fin; i++) begin
      tick();
      if (wr_q.size() >= 12) fin = 1'b1;
    end
    check("midreset.reached", fin, 1);
    rst_n = 1'b0;
    tick();
    reset_checks("midreset");
    rst_n = 1'b1;
    last_rx = 8'd0;
    tick();
    run_frame(2'd0, $urandom_range(0, 2), 0, 1'b0, "restart");

`ifdef AVM_IMAGE_STREAMER_WATCHDOG_EN
    stuck = 1'b1;
    start_frame(2'd0, 0, 0);
    fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      tick();
      if (o_error) fin = 1'b1;
    end
    repeat (3) tick();
    check("wd.error_set",   fin, 1);
    check("wd.busy_cycles", busy_cnt, 21);
    check("wd.no_done",     done_cnt, 0);
    check("wd.idle",        o_state, 0);
    check("wd.sticky",      o_error, 1);
    stuck = 1'b0;
    randomize_data();
    run_frame(2'd1, 0, 0, 1'b0, "wd.recover");
`endif

    check("bus.address_map", addr_bad, 0);
    check("bus.stall_stable", stab_bad, 0);
    check("bus.one_strobe", both_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
